// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcodes and format codes shared by the immediate-generation stage.
package imm_gen_pkg;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_ILL  = 3'd7
  } fmt_e;
endpackage

// File: rtl/imm_gen_stage_decode.sv
// imm_decode: combinational RV32I/RV64I immediate extraction, format tagging and opcode legality.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);
  localparam bit RV64 = XLEN == 64;
  logic [6:0] opc;
  logic sh;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  assign opc = instr[6:0];
  // funct3 001 (SLLI) and 101 (SRLI/SRAI) share bits [13:12] = 01
  assign sh = instr[13:12] == 2'b01;
  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_sh = (RV64 && opc == OPC_OPIMM) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    illegal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        imm = imm_i;
        fmt = FMT_I;
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        illegal = opc == OPC_OPIMM32 && !RV64;
        fmt = illegal ? FMT_ILL : sh ? FMT_SH : FMT_I;
        imm = illegal ? '0 : sh ? imm_sh : imm_i;
      end
      OPC_STORE: begin
        imm = imm_s;
        fmt = FMT_S;
      end
      OPC_BRANCH: begin
        imm = imm_b;
        fmt = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm = imm_u;
        fmt = FMT_U;
      end
      OPC_JAL: begin
        imm = imm_j;
        fmt = FMT_J;
      end
      OPC_OP, OPC_FENCE: fmt = FMT_NONE;
      OPC_OP32: begin
        illegal = !RV64;
        fmt = RV64 ? FMT_NONE : FMT_ILL;
      end
      default: begin
        illegal = 1'b1;
        fmt = FMT_ILL;
      end
    endcase
  end
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage with valid/ready handshake,
// optional two-entry skid buffer and saturating illegal-instruction counter.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  logic [XLEN-1:0] d_imm;
  logic [2:0] d_fmt;
  logic d_ill;
  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (d_imm),
    .fmt     (d_fmt),
    .illegal (d_ill)
  );
  // With SKID=0 only entry 0 is ever used and the pointers stay at 0
  logic [31:0]     e_instr [2];
  logic [XLEN-1:0] e_pc    [2];
  logic [XLEN-1:0] e_imm   [2];
  logic [2:0]      e_fmt   [2];
  logic            e_ill   [2];
  logic rd_ptr, wr_ptr, rst_n_q, rdy_q, push, pop;
  logic [1:0] cnt, cnt_nxt;
  assign out_valid = cnt != 2'd0;
  assign in_ready = SKID != 0 ? rdy_q : rst_n_q & (~out_valid | out_ready);
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready;
  assign cnt_nxt = cnt + 2'(push) - 2'(pop);
  assign out_instr = e_instr[rd_ptr];
  assign out_pc = e_pc[rd_ptr];
  assign out_imm = e_imm[rd_ptr];
  assign out_fmt = e_fmt[rd_ptr];
  assign out_illegal = e_ill[rd_ptr];
  always_ff @(posedge clk) rst_n_q <= rst_n;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      e_instr <= '{default: '0};
      e_pc <= '{default: '0};
      e_imm <= '{default: '0};
      e_fmt <= '{default: '0};
      e_ill <= '{default: '0};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt <= 2'd0;
      rdy_q <= rst_n;
    end else begin
      if (push) begin
        e_instr[wr_ptr] <= in_instr;
        e_pc[wr_ptr] <= in_pc;
        e_imm[wr_ptr] <= d_imm;
        e_fmt[wr_ptr] <= d_fmt;
        e_ill[wr_ptr] <= d_ill;
        wr_ptr <= SKID != 0 ? ~wr_ptr : 1'b0;
      end
      if (pop) rd_ptr <= SKID != 0 ? ~rd_ptr : 1'b0;
      cnt <= cnt_nxt;
      rdy_q <= cnt_nxt < 2'd2;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_cnt <= '0;
    else if (push && d_ill && !(&illegal_cnt)) illegal_cnt <= illegal_cnt + 1'b1;
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: table-driven immediate checks on RV32/RV64 instances plus skid, flush,
// counter-saturation and reset sequences.
module tb_imm_gen_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  always #5 clk = ~clk;
  logic a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_instr, a_pc, a_imm;
  logic [2:0] a_fmt;
  logic [15:0] a_cnt;
  logic b_in_ready, b_out_valid, b_ill;
  logic [31:0] b_instr;
  logic [63:0] b_pc, b_imm;
  logic [2:0] b_fmt;
  logic [15:0] b_cnt;
  logic c_in_ready, c_out_valid, c_ill;
  logic [31:0] c_instr, c_pc, c_imm;
  logic [2:0] c_fmt;
  logic [1:0] c_cnt;
  imm_gen_stage #(.XLEN(32), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_instr(a_instr), .out_pc(a_pc), .out_imm(a_imm), .out_fmt(a_fmt),
    .out_illegal(a_ill), .illegal_cnt(a_cnt));
  imm_gen_stage #(.XLEN(64), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_instr(b_instr), .out_pc(b_pc), .out_imm(b_imm), .out_fmt(b_fmt),
    .out_illegal(b_ill), .illegal_cnt(b_cnt));
  imm_gen_stage #(.XLEN(32), .SKID(0), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_instr(c_instr), .out_pc(c_pc), .out_imm(c_imm), .out_fmt(c_fmt),
    .out_illegal(c_ill), .illegal_cnt(c_cnt));
  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
  } vec_t;
  vec_t vecs[19];
  int n_vec = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic send(input logic [31:0] ins, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc = pc;
    tick;
    in_valid = 1'b0;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  logic [31:0] exp3[3];
  logic [63:0] pc;
  logic pushing;
  int got;
  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1};
    vecs[1]  = '{32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2};
    vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 64'hFFFFFFFFFFFFFFF8, 3'd3};
    vecs[3]  = '{32'h0010006F, 32'h00000800, 3'd5, 64'h0000000000000800, 3'd5};
    vecs[4]  = '{32'h123452B7, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4};
    vecs[5]  = '{32'h01F09093, 32'h0000001F, 3'd6, 64'h000000000000001F, 3'd6};
    vecs[6]  = '{32'h800002B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4};
    vecs[7]  = '{32'h03F09093, 32'h0000001F, 3'd6, 64'h000000000000003F, 3'd6};
    vecs[8]  = '{32'hFFF0009B, 32'h00000000, 3'd7, 64'hFFFFFFFFFFFFFFFF, 3'd1};
    vecs[9]  = '{32'h0000007F, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7};
    vecs[10] = '{32'h40B50533, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0};
    vecs[11] = '{32'h0000003B, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd0};
    vecs[12] = '{32'h01F0909B, 32'h00000000, 3'd7, 64'h000000000000001F, 3'd6};
    vecs[13] = '{32'h4030D093, 32'h00000003, 3'd6, 64'h0000000000000003, 3'd6};
    vecs[14] = '{32'h80002083, 32'hFFFFF800, 3'd1, 64'hFFFFFFFFFFFFF800, 3'd1};
    vecs[15] = '{32'h0FF0000F, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0};
    vecs[16] = '{32'hFFFFF297, 32'hFFFFF000, 3'd4, 64'hFFFFFFFFFFFFF000, 3'd4};
    vecs[17] = '{32'hFFC08067, 32'hFFFFFFFC, 3'd1, 64'hFFFFFFFFFFFFFFFC, 3'd1};
    vecs[18] = '{32'h00000073, 32'h00000000, 3'd1, 64'h0000000000000000, 3'd1};
    tick;
    tick;
    chk("rst a_in_ready", a_in_ready, 0);
    chk("rst b_in_ready", b_in_ready, 0);
    chk("rst a_out_valid", a_out_valid, 0);
    chk("rst a_imm", a_imm, 0);
    chk("rst a_fmt", a_fmt, 0);
    chk("rst a_ill", a_ill, 0);
    chk("rst a_cnt", a_cnt, 0);
    chk("rst b_imm", b_imm, 0);
    rst_n = 1'b1;
    chk("release a_in_ready same cycle", a_in_ready, 0);
    chk("release b_in_ready same cycle", b_in_ready, 0);
    tick;
    chk("release a_in_ready", a_in_ready, 1);
    chk("release b_in_ready", b_in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      pc = 64'hFFFF000000001000 + 64'(i * 4);
      send(vecs[i].instr, pc);
      chk($sformatf("v%0d a_valid", i), a_out_valid, 1);
      chk($sformatf("v%0d a_imm", i), a_imm, vecs[i].imm32);
      chk($sformatf("v%0d a_fmt", i), a_fmt, vecs[i].fmt32);
      chk($sformatf("v%0d a_ill", i), a_ill, vecs[i].fmt32 == 3'd7);
      chk($sformatf("v%0d a_instr", i), a_instr, vecs[i].instr);
      chk($sformatf("v%0d a_pc", i), a_pc, pc[31:0]);
      chk($sformatf("v%0d b_valid", i), b_out_valid, 1);
      chk($sformatf("v%0d b_imm", i), b_imm, vecs[i].imm64);
      chk($sformatf("v%0d b_fmt", i), b_fmt, vecs[i].fmt64);
      chk($sformatf("v%0d b_ill", i), b_ill, vecs[i].fmt64 == 3'd7);
      chk($sformatf("v%0d b_pc", i), b_pc, pc);
      tick;
      chk($sformatf("v%0d a_drained", i), a_out_valid, 0);
    end
    chk("table a_cnt", a_cnt, 4);
    chk("table b_cnt", b_cnt, 1);
    chk("table c_cnt sat", c_cnt, 3);
    do_reset;
    for (int i = 0; i < 3; i++) begin
      send(32'h0000007F, 0);
      chk("ill7f a_ill", a_ill, 1);
      chk("ill7f a_imm", a_imm, 0);
      tick;
    end
    chk("ill x3 a_cnt", a_cnt, 3);
    chk("ill x3 c_cnt", c_cnt, 3);
    for (int i = 0; i < 2; i++) begin
      send(32'h0000007F, 0);
      tick;
    end
    chk("ill x5 a_cnt", a_cnt, 5);
    chk("ill x5 c_cnt sat", c_cnt, 3);
    flush = 1'b1;
    send(32'h0000007F, 0);
    flush = 1'b0;
    chk("flush in a_valid", a_out_valid, 0);
    chk("flush in b_valid", b_out_valid, 0);
    chk("flush in a_cnt", a_cnt, 5);
    chk("flush in b_cnt", b_cnt, 5);
    exp3 = '{32'h00100093, 32'h00200093, 32'h00300093};
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = exp3[i];
      tick;
    end
    chk("skid full in_ready", a_in_ready, 0);
    chk("skid head instr", a_instr, exp3[0]);
    chk("skid head imm", a_imm, 1);
    chk("skid b_in_ready", b_in_ready, 0);
    got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12 && (got < 3 || in_valid); cyc++) begin
      pushing = in_valid & a_in_ready;
      if (a_out_valid && out_ready) begin
        if (got < 3) chk("skid order", a_instr, exp3[got]);
        got++;
      end
      tick;
      if (pushing) in_valid = 1'b0;
    end
    chk("skid delivered", got, 3);
    chk("skid empty", a_out_valid, 0);
    out_ready = 1'b0;
    send(32'h00400093, 0);
    send(32'h00500093, 0);
    chk("hold2 a_valid", a_out_valid, 1);
    chk("hold2 a_in_ready", a_in_ready, 0);
    chk("hold b_in_ready", b_in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("comb b_in_ready", b_in_ready, 1);
    out_ready = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush2 a_valid", a_out_valid, 0);
    chk("flush2 b_valid", b_out_valid, 0);
    chk("flush2 a_in_ready", a_in_ready, 1);
    chk("flush2 a_instr", a_instr, 0);
    send(32'h00600093, 0);
    chk("mid a_valid", a_out_valid, 1);
    rst_n = 1'b0;
    tick;
    chk("midrst a_valid", a_out_valid, 0);
    chk("midrst a_in_ready", a_in_ready, 0);
    chk("midrst b_in_ready", b_in_ready, 0);
    chk("midrst a_imm", a_imm, 0);
    chk("midrst a_instr", a_instr, 0);
    chk("midrst a_cnt", a_cnt, 0);
    chk("midrst b_valid", b_out_valid, 0);
    rst_n = 1'b1;
    chk("midrel a_in_ready same", a_in_ready, 0);
    tick;
    chk("midrel a_in_ready", a_in_ready, 1);
    chk("midrel b_in_ready", b_in_ready, 1);
    chk("midrel a_valid", a_out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
